hazard_event_monitor: RTL

//   Consumes the three hazard indicator levels (forward, stall, flush) that the

---
 rtl/hazard_event_monitor.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_event_monitor.sv
// Stretches forward/stall/flush hazard levels into visible LED pulses and
// counts their rising edges in saturating counters behind a registered mux.
module hazard_event_monitor #(
    parameter int STRETCH_CYCLES = 5_000_000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_evt,
    input  logic             stall_evt,
    input  logic             flush_evt,
    input  logic             clear_cnt,
    input  logic [1:0]       sel,
    output logic             led_fwd,
    output logic             led_stall,
    output logic             led_flush,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int TW = $clog2(STRETCH_CYCLES);
    localparam logic [TW-1:0] RELOAD = TW'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic [2:0] evt;
    logic [2:0] evt_d;
    logic [2:0] rise;

    state_t        state_q [3];
    state_t        state_d [3];
    logic [TW-1:0] timer_q [3];
    logic [TW-1:0] timer_d [3];

    logic [CNT_W-1:0] cnt_q [4];

    // Channel index: 0=fwd, 1=stall, 2=flush
    assign evt  = {flush_evt, stall_evt, fwd_evt};
    assign rise = evt & ~evt_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = HOLD;
                        timer_d[i] = RELOAD;
                    end
                end
                HOLD: begin
                    if (rise[i]) begin
                        timer_d[i] = RELOAD;
                    end else if (timer_q[i] == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        timer_d[i] = timer_q[i] - 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_d <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            evt_d <= evt;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign led_fwd   = (state_q[0] == HOLD);
    assign led_stall = (state_q[1] == HOLD);
    assign led_flush = (state_q[2] == HOLD);

    // Readout samples pre-update values; clear beats a same-cycle rise
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_out <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_out <= cnt_q[sel];
            if (clear_cnt) begin
                for (int i = 0; i < 4; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (rise[i] && (cnt_q[i] != CNT_MAX)) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
                if (cnt_q[3] != CNT_MAX) begin
                    cnt_q[3] <= cnt_q[3] + 1'b1;
                end
            end
        end
    end

endmodule
